// File: rtl/minimig_autoconfig_chain.sv
// rtl/minimig_autoconfig_chain.sv - Zorro II/III AutoConfig chain controller at $E80000
module minimig_autoconfig_chain #(
    parameter int NUM_BOARDS = 3,
    parameter logic [NUM_BOARDS-1:0] BOARD_Z3 = 3'b110,
    localparam int IDXW = $clog2(NUM_BOARDS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BOARDS-1:0]   board_en,
    input  logic                    cfg_we,
    input  logic [IDXW+5:0]         cfg_addr,
    input  logic [3:0]              cfg_d,
    input  logic                    ac_req,
    input  logic                    ac_wr,
    input  logic [5:0]              ac_addr,
    input  logic [15:0]             ac_din,
    output logic                    ac_ack,
    output logic [3:0]              ac_q,
    output logic [IDXW-1:0]         cur_board,
    output logic [NUM_BOARDS-1:0]   configured,
    output logic [16*NUM_BOARDS-1:0] base_addr,
    output logic                    config_done
);
    localparam int EN_W = 1 << IDXW;
    localparam logic [EN_W-1:0] Z3_PAD = EN_W'(BOARD_Z3);
    localparam logic [IDXW-1:0] LAST   = IDXW'(NUM_BOARDS);

    typedef enum logic [1:0] {SEEK, PRESENT, DONE} state_t;
    state_t state, state_next;

    // Nibble tables start erased (all F) so an unloaded board reads as "no board"
    logic [3:0] table_ram [0:(1 << (IDXW + 6)) - 1] = '{default: 4'hF};
    logic [3:0] ram_q;
    logic       q_sel;
    logic [15:0] base_r [NUM_BOARDS];
    logic [EN_W-1:0] en_pad;

    logic accept, wr_present, cur_z3;
    logic wr_lo, wr_hi, wr_z3, shutup, advance, seek_skip;

    assign en_pad = EN_W'(board_en);

    // Registered read port; a same-cycle cfg write to the same cell yields the old nibble
    always_ff @(posedge clk) begin
        if (cfg_we)
            table_ram[cfg_addr] <= cfg_d;
        ram_q <= table_ram[{cur_board, ac_addr}];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= SEEK;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SEEK: begin
                if (cur_board == LAST)
                    state_next = DONE;
                else if (en_pad[cur_board])
                    state_next = PRESENT;
            end
            PRESENT: if (advance) state_next = SEEK;
            DONE:    state_next = DONE;
            default: state_next = SEEK;
        endcase
    end

    always_comb begin
        accept      = ac_req && !ac_ack && (state != SEEK);
        wr_present  = accept && (state == PRESENT) && ac_wr;
        cur_z3      = Z3_PAD[cur_board];
        wr_lo       = wr_present && (ac_addr == 6'h25) && !cur_z3;
        wr_hi       = wr_present && (ac_addr == 6'h24) && !cur_z3;
        wr_z3       = wr_present && (ac_addr == 6'h22) && cur_z3;
        shutup      = wr_present && (ac_addr == 6'h26);
        advance     = wr_hi || wr_z3 || shutup;
        seek_skip   = (state == SEEK) && (cur_board != LAST) && !en_pad[cur_board];
        config_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ac_ack     <= 1'b0;
            q_sel      <= 1'b0;
            cur_board  <= '0;
            configured <= '0;
            for (int k = 0; k < NUM_BOARDS; k++)
                base_r[k] <= 16'h0000;
        end else begin
            ac_ack <= accept;
            q_sel  <= accept && (state == PRESENT) && !ac_wr;
            if (seek_skip || advance)
                cur_board <= cur_board + 1'b1;
            for (int k = 0; k < NUM_BOARDS; k++) begin
                if (cur_board == IDXW'(k)) begin
                    if (wr_lo)
                        base_r[k][3:0] <= ac_din[15:12];
                    if (wr_hi) begin
                        base_r[k][7:4] <= ac_din[15:12];
                        configured[k]  <= 1'b1;
                    end
                    if (wr_z3) begin
                        base_r[k]     <= ac_din;
                        configured[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Outside a PRESENT read acknowledge the bus sees an empty (all-ones) nibble
    assign ac_q = q_sel ? ram_q : 4'hF;

    for (genvar g = 0; g < NUM_BOARDS; g++) begin : g_base
        assign base_addr[16*g +: 16] = base_r[g];
    end
endmodule
